// File: rtl/div_pkg.sv
// div_pkg: shared state encodings and sizing for the sequential divider.
package div_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   localparam int WIDTH_DEF = 32;
   localparam int CNT_W = 6;
endpackage

// File: rtl/div_fa.sv
// div_fa: single-bit full-adder cell used by the ripple subtractors.
module div_fa (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// File: rtl/div_step.sv
// div_step: combinational ripple subtractor o_d = i_a - i_b (a + ~b + 1).
module div_step #(
   parameter int N = 33
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic [N-1:0] o_d
);
   logic [N-1:0] w_c;
   assign w_c[0] = 1'b1;
   for (genvar i = 0; i < N - 1; i++) begin : g_fa
      div_fa u_fa (.i_a(i_a[i]), .i_b(~i_b[i]), .i_c(w_c[i]), .o_s(o_d[i]), .o_c(w_c[i+1]));
   end
   // the top bit's carry-out is never needed, so only its sum is formed
   assign o_d[N-1] = i_a[N-1] ^ ~i_b[N-1] ^ w_c[N-1];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: signed restoring divider, one quotient bit per clock, WIDTH-cycle run.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_remainder,
   output logic             data_exception,
   output logic             data_resultRDY
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
   state_t r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
   logic r_qs, r_rs;
   logic [WIDTH-1:0] w_neg_a, w_neg_b, w_abs_a, w_abs_b;
   logic [WIDTH-1:0] w_q_next, w_r_next, w_neg_q, w_neg_r;
   logic [WIDTH:0] w_shift, w_diff;
   logic w_last;

   div_step #(.N(WIDTH)) u_neg_a (.i_a('0), .i_b(data_operandA), .o_d(w_neg_a));
   div_step #(.N(WIDTH)) u_neg_b (.i_a('0), .i_b(data_operandB), .o_d(w_neg_b));
   assign w_abs_a = data_operandA[WIDTH-1] ? w_neg_a : data_operandA;
   assign w_abs_b = data_operandB[WIDTH-1] ? w_neg_b : data_operandB;

   // remainder stays below |B| <= 2^(WIDTH-1), so the trial difference fits signed WIDTH+1
   assign w_shift = {r_rem, r_quo[WIDTH-1]};
   div_step #(.N(WIDTH + 1)) u_trial (.i_a(w_shift), .i_b({1'b0, r_dvs}), .o_d(w_diff));
   assign w_q_next = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
   assign w_r_next = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];

   div_step #(.N(WIDTH)) u_neg_q (.i_a('0), .i_b(w_q_next), .o_d(w_neg_q));
   div_step #(.N(WIDTH)) u_neg_r (.i_a('0), .i_b(w_r_next), .o_d(w_neg_r));

   assign w_last = (r_state == RUN) && (r_cnt == LAST);

   always_comb begin
      w_next = r_state;
      if (ctrl_DIV) w_next = (data_operandB == '0) ? DONE : RUN;
      else if (r_state == DONE) w_next = IDLE;
      else if (w_last) w_next = DONE;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= IDLE;
         r_cnt          <= '0;
         data_result    <= '0;
         data_remainder <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         r_state        <= w_next;
         data_resultRDY <= (w_next == DONE);
         if (ctrl_DIV) begin
            r_quo          <= w_abs_a;
            r_dvs          <= w_abs_b;
            r_qs           <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_rs           <= data_operandA[WIDTH-1];
            r_rem          <= '0;
            r_cnt          <= '0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= (data_operandB == '0);
         end else if (r_state == RUN) begin
            r_quo <= w_q_next;
            r_rem <= w_r_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
               data_result    <= r_qs ? w_neg_q : w_q_next;
               data_remainder <= r_rs ? w_neg_r : w_r_next;
            end
         end
      end
   end
endmodule
